exposure_readout_sequencer: RTL and testbench
=============================================

Name: exposure_readout_sequencer

Overview:
Sits directly downstream of the exposure-trigger handshake stage. It consumes the active-low, level-held exp_trigger request and runs one frame: per-subframe mask request, timed pixel exposure, a pre-readout gap, then row-by-row readout. It drives re_busy back to the trigger stage for the duration of readout, which closes that handshake, and pulses frame_done when the last row is accepted.

Parameters:
SUBF_W, 16, width of num_subframes and subframe_idx
EXP_W, 24, width of exp_cycles (exposure length in clk cycles)
ROW_W, 10, width of row_addr
NUM_ROWS, 320, rows per readout (1..2^ROW_W)
GAP_CYCLES, 4, idle cycles between last exposure and readout start (0 allowed)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
exp_trigger  in  1  frame request, active low, held low until re_busy is seen
num_subframes  in  SUBF_W  subframes per frame, sampled at frame start
exp_cycles  in  EXP_W  exposure cycles per subframe, sampled at frame start
mask_req  out  1  one-cycle pulse requesting the next subframe mask
mask_ready  in  1  mask loaded; level or pulse
expose  out  1  pixel exposure enable
subframe_idx  out  SUBF_W  current subframe, 0-based
re_busy  out  1  readout in progress
row_valid  out  1  row_addr valid for the ADC/FIFO stage
row_addr  out  ROW_W  current readout row
row_ack  in  1  row accepted when row_valid&row_ack
frame_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; armed=0; internal counters 0.
- armed: set in any cycle where exp_trigger==1. Cleared on frame start. A frame starts only when exp_trigger is held low after it has been seen high. This blocks retrigger on a stale low level.
- FSM states: IDLE, MASK_REQ, MASK_WAIT, EXPOSE, GAP, READOUT, DONE.
- IDLE: when exp_trigger==0 and armed:
  - latch num_subframes into n_sub and exp_cycles into n_exp;
  - a value of 0 is replaced by 1 for each;
  - subframe_idx<=0; go to MASK_REQ.
  - Input changes after the latch are ignored until the next frame.
- MASK_REQ: mask_req=1 for exactly this one cycle; go to MASK_WAIT.
- MASK_WAIT: wait for mask_ready==1, with no timeout. mask_ready high during MASK_REQ is ignored; the sequencer samples it only in MASK_WAIT. On mask_ready go to EXPOSE and load exp_cnt=n_exp-1.
- EXPOSE: expose=1 for exactly n_exp consecutive cycles; exp_cnt decrements each cycle. When exp_cnt==0:
  - if subframe_idx==n_sub-1, go to GAP, loading gap_cnt=GAP_CYCLES;
  - else increment subframe_idx and go to MASK_REQ.
  - expose drops the cycle after the last exposure cycle, with no bubble inside a subframe.
- GAP: all outputs idle for GAP_CYCLES cycles. With GAP_CYCLES=0, the FSM passes through GAP in one cycle.
- READOUT:
  - on entry re_busy=1, row_valid=1, row_addr=0;
  - row_addr advances by 1 on each cycle with row_valid&row_ack, and holds while row_ack==0;
  - row_addr and row_valid must not change while unacknowledged.
  - After the handshake on row NUM_ROWS-1, go to DONE.
  - re_busy stays high through the last handshake cycle.
- DONE: frame_done=1 for one cycle; re_busy=0; row_valid=0; row_addr=0; go to IDLE.
- Counter widths: exp_cnt is EXP_W and row counter is ROW_W bits, with no wrap inside a frame. subframe_idx never exceeds n_sub-1.
- Latency: exp_trigger low sampled at edge k in IDLE (armed) gives mask_req high during cycle k+1.
- Reset mid-frame: all outputs drop immediately with reset assertion. After release the FSM is in IDLE with armed=0.
- exp_trigger rising mid-frame (upstream abort) is ignored except that it sets armed. The frame always completes.

Test Plan:
1. NUM_ROWS=4, GAP_CYCLES=2; num_subframes=2, exp_cycles=5; mask_ready tied 1, row_ack tied 1 -> two mask_req pulses; expose high 5 cycles twice, subframe_idx 0 then 1; 2 gap cycles; row_addr 0,1,2,3 with re_busy high 4 cycles; one frame_done.
2. num_subframes=0, exp_cycles=0 -> treated as 1/1: single mask_req, expose high exactly 1 cycle, normal readout.
3. Readout backpressure: row_ack pattern 1,0,0,1,1,0,1 with NUM_ROWS=4 -> row_addr holds during ack=0; 4 handshakes total; frame_done one cycle after the 4th.
4. mask_ready delayed 10 cycles after mask_req -> expose starts the cycle after mask_ready, never before; mask_ready high during MASK_REQ only does not start exposure.
5. exp_trigger held low across frame_done -> no second frame. exp_trigger raised 1 cycle then lowered -> second frame starts, mask_req the following cycle.
6. rst_n asserted mid-EXPOSE -> expose, re_busy and mask_req go 0 without a clock edge. After release with exp_trigger still low there is no frame until exp_trigger goes high then low.

Source files
------------

// File: rtl/exposure_readout_sequencer.sv
// Frame sequencer: per-subframe mask request and timed exposure, a pre-readout
// gap, then row-by-row readout with valid/ack handshake and a frame_done pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for exp_trigger low while armed
// MASK_REQ  | one-cycle mask_req pulse for the current subframe
// MASK_WAIT | waiting for mask_ready
// EXPOSE    | expose high for n_exp cycles
// GAP       | idle spacing before readout
// READOUT   | row_valid/row_addr offered, advance on row_ack
// DONE      | one-cycle frame_done pulse
module exposure_readout_sequencer #(
  parameter int SUBF_W     = 16,
  parameter int EXP_W      = 24,
  parameter int ROW_W      = 10,
  parameter int NUM_ROWS   = 320,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_trigger,
  input  logic [SUBF_W-1:0] num_subframes,
  input  logic [EXP_W-1:0]  exp_cycles,
  output logic              mask_req,
  input  logic              mask_ready,
  output logic              expose,
  output logic [SUBF_W-1:0] subframe_idx,
  output logic              re_busy,
  output logic              row_valid,
  output logic [ROW_W-1:0]  row_addr,
  input  logic              row_ack,
  output logic              frame_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MASK_REQ, S_MASK_WAIT, S_EXPOSE, S_GAP, S_READOUT, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              armed;
  logic [SUBF_W-1:0] n_sub;
  logic [EXP_W-1:0]  n_exp;
  logic [EXP_W-1:0]  exp_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic start, last_exp, last_sub, gap_end, last_row;

  assign start    = (state == S_IDLE) && !exp_trigger && armed;
  assign last_exp = (exp_cnt == '0);
  assign last_sub = (subframe_idx == n_sub - SUBF_W'(1));
  // Terminal count at 1 gives GAP_CYCLES idle cycles, and a single pass-through cycle when 0.
  assign gap_end  = (gap_cnt <= GAP_W'(1));
  assign last_row = (row_addr == LAST_ROW);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_MASK_REQ;
      S_MASK_REQ:  state_nxt = S_MASK_WAIT;
      S_MASK_WAIT: if (mask_ready) state_nxt = S_EXPOSE;
      S_EXPOSE:    if (last_exp) state_nxt = last_sub ? S_GAP : S_MASK_REQ;
      S_GAP:       if (gap_end) state_nxt = S_READOUT;
      S_READOUT:   if (row_ack && last_row) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      n_sub        <= '0;
      n_exp        <= '0;
      exp_cnt      <= '0;
      gap_cnt      <= '0;
      subframe_idx <= '0;
      row_addr     <= '0;
    end else begin
      // A trigger seen high re-arms, even mid-frame; a stale low level cannot retrigger.
      if (exp_trigger)  armed <= 1'b1;
      else if (start)   armed <= 1'b0;

      if (start) begin
        n_sub        <= (num_subframes == '0) ? SUBF_W'(1) : num_subframes;
        n_exp        <= (exp_cycles == '0) ? EXP_W'(1) : exp_cycles;
        subframe_idx <= '0;
      end

      unique case (state)
        S_MASK_WAIT: if (mask_ready) exp_cnt <= n_exp - EXP_W'(1);
        S_EXPOSE: begin
          if (!last_exp)     exp_cnt <= exp_cnt - EXP_W'(1);
          else if (last_sub) gap_cnt <= GAP_LOAD;
          else               subframe_idx <= subframe_idx + SUBF_W'(1);
        end
        S_GAP:     if (!gap_end) gap_cnt <= gap_cnt - GAP_W'(1);
        S_READOUT: if (row_ack) row_addr <= last_row ? '0 : row_addr + ROW_W'(1);
        default: ;
      endcase
    end
  end

  assign mask_req   = (state == S_MASK_REQ);
  assign expose     = (state == S_EXPOSE);
  assign re_busy    = (state == S_READOUT);
  assign row_valid  = (state == S_READOUT);
  assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_exposure_readout_sequencer.sv
// Bench for exposure_readout_sequencer: directed scenarios plus randomized frames,
// each frame's cycle-by-cycle output timeline derived from the frame parameters.
module tb_exposure_readout_sequencer;
  localparam int SUBF_W     = 16;
  localparam int EXP_W      = 24;
  localparam int ROW_W      = 10;
  localparam int NUM_ROWS   = 4;
  localparam int GAP_CYCLES = 2;

  // Output vector bits: {mask_req, expose, re_busy, row_valid, frame_done}
  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_MREQ = 5'b10000;
  localparam logic [4:0] V_EXP  = 5'b01000;
  localparam logic [4:0] V_RD   = 5'b00110;
  localparam logic [4:0] V_DONE = 5'b00001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              exp_trigger;
  logic [SUBF_W-1:0] num_subframes;
  logic [EXP_W-1:0]  exp_cycles;
  logic              mask_req;
  logic              mask_ready;
  logic              expose;
  logic [SUBF_W-1:0] subframe_idx;
  logic              re_busy;
  logic              row_valid;
  logic [ROW_W-1:0]  row_addr;
  logic              row_ack;
  logic              frame_done;

  int total = 0;
  int bad   = 0;
  int ack_pat[$];

  exposure_readout_sequencer #(
    .SUBF_W(SUBF_W), .EXP_W(EXP_W), .ROW_W(ROW_W),
    .NUM_ROWS(NUM_ROWS), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .exp_trigger(exp_trigger),
    .num_subframes(num_subframes), .exp_cycles(exp_cycles),
    .mask_req(mask_req), .mask_ready(mask_ready), .expose(expose),
    .subframe_idx(subframe_idx), .re_busy(re_busy), .row_valid(row_valid),
    .row_addr(row_addr), .row_ack(row_ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [4:0] exp_vec, input int exp_row,
                           input int exp_sub);
    check_val({tag, "_out"}, 32'({mask_req, expose, re_busy, row_valid, frame_done}),
              32'(exp_vec));
    check_val({tag, "_row"}, 32'(row_addr), 32'(exp_row));
    if (exp_sub >= 0) check_val({tag, "_sub"}, 32'(subframe_idx), 32'(exp_sub));
  endtask

  // Expected timeline: [arm] idle, mask_req, spurious-ready cycle ignored, d waits,
  // ready cycle, ne expose cycles per subframe, gap, rows until NUM_ROWS acks, done.
  // ack_mode: 0 tied high, 1 from ack_pat, 2 random. mdly<0 picks a random delay.
  task automatic run_frame(input bit arm, input int ns_in, input int ne_in, input int mdly,
                           input bit spur, input int ack_mode, input bit abort);
    int ns, ne, d, r, ack_i, gap_n, guard;
    bit ack;
    ns    = (ns_in == 0) ? 1 : ns_in;
    ne    = (ne_in == 0) ? 1 : ne_in;
    gap_n = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    if (arm) begin
      chk_cycle("idle_arm", V_IDLE, 0, -1);
      exp_trigger = 1'b1;
      @(negedge clk);
    end
    chk_cycle("idle_start", V_IDLE, 0, -1);
    exp_trigger   = 1'b0;
    num_subframes = ns_in[SUBF_W-1:0];
    exp_cycles    = ne_in[EXP_W-1:0];
    @(negedge clk);
    for (int s = 0; s < ns; s++) begin
      chk_cycle("mreq", V_MREQ, 0, s);
      if (s == 0) begin
        num_subframes = SUBF_W'($urandom_range(0, 9));
        exp_cycles    = EXP_W'($urandom_range(0, 9));
      end
      mask_ready = spur;
      @(negedge clk);
      d = (mdly < 0) ? $urandom_range(0, 4) : mdly;
      for (int k = 0; k < d; k++) begin
        chk_cycle("mwait", V_IDLE, 0, s);
        mask_ready = 1'b0;
        @(negedge clk);
      end
      chk_cycle("mwait_rdy", V_IDLE, 0, s);
      mask_ready = 1'b1;
      @(negedge clk);
      for (int e = 0; e < ne; e++) begin
        chk_cycle("expose", V_EXP, 0, s);
        mask_ready  = 1'($urandom_range(0, 1));
        exp_trigger = abort && (s == 0) && (e == 0);
        @(negedge clk);
      end
      exp_trigger = 1'b0;
    end
    for (int g = 0; g < gap_n; g++) begin
      chk_cycle("gap", V_IDLE, 0, -1);
      row_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    r = 0;
    ack_i = 0;
    guard = 0;
    while (r < NUM_ROWS && guard < 200) begin
      chk_cycle("read", V_RD, r, -1);
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (ack_i < ack_pat.size()) ? ack_pat[ack_i][0] : 1'b1;
        default: ack = 1'($urandom_range(0, 1));
      endcase
      row_ack = ack;
      ack_i++;
      guard++;
      @(negedge clk);
      if (ack) r++;
    end
    chk_cycle("done", V_DONE, 0, -1);
    row_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  initial begin
    bit prev_abort;
    bit ab;
    rst_n         = 1'b0;
    exp_trigger   = 1'b1;
    num_subframes = '0;
    exp_cycles    = '0;
    mask_ready    = 1'b0;
    row_ack       = 1'b0;
    repeat (3) @(negedge clk);
    chk_cycle("reset", V_IDLE, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two subframes of 5, mask_ready and row_ack tied high.
    run_frame(1'b1, 2, 5, 0, 1'b1, 0, 1'b0);
    // Zero parameters behave as one subframe of one cycle.
    run_frame(1'b1, 0, 0, 0, 1'b0, 0, 1'b0);
    // Readout backpressure.
    ack_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_frame(1'b1, 1, 2, 0, 1'b0, 1, 1'b0);
    // Late mask_ready, with a ready pulse during the request cycle only.
    run_frame(1'b1, 2, 3, 10, 1'b1, 0, 1'b0);

    // Trigger held low after a frame: no retrigger.
    for (int i = 0; i < 8; i++) begin
      chk_cycle("stale_low", V_IDLE, 0, -1);
      @(negedge clk);
    end
    run_frame(1'b1, 1, 1, 0, 1'b0, 0, 1'b0);

    // Trigger pulse mid-frame is ignored but re-arms for an immediate next frame.
    run_frame(1'b1, 2, 2, 1, 1'b0, 2, 1'b1);
    run_frame(1'b0, 1, 3, 0, 1'b0, 2, 1'b0);

    // Asynchronous reset in the middle of exposure.
    exp_trigger = 1'b1;
    @(negedge clk);
    exp_trigger   = 1'b0;
    num_subframes = SUBF_W'(1);
    exp_cycles    = EXP_W'(20);
    @(negedge clk);
    mask_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_cycle("pre_rst_exp", V_EXP, 0, 0);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_cycle("rst_async", V_IDLE, 0, -1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk_cycle("post_rst", V_IDLE, 0, -1);
      @(negedge clk);
    end
    run_frame(1'b1, 1, 2, 0, 1'b0, 0, 1'b0);

    // Randomized frames.
    prev_abort = 1'b0;
    for (int f = 0; f < 15; f++) begin
      ab = 1'($urandom_range(0, 1));
      run_frame(!prev_abort, $urandom_range(0, 3), $urandom_range(0, 6), -1,
                1'($urandom_range(0, 1)), 2, ab);
      prev_abort = ab;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
